// File: rtl/trs80_cas_pkg.sv
// Shared definitions for the TRS-80 cassette playback path: player FSM states,
// default bit-cell timing at 42 MHz and the cassette image base in the dn_* RAM map.
package trs80_cas_pkg;

    localparam int CELL_CYC_DEF  = 84000;  // 2 ms bit cell at 42 MHz (500 baud)
    localparam int PULSE_CYC_DEF = 5250;   // 125 us pulse high time

    // rd_addr is an offset; the integrator adds this base on the dn_* RAM path.
    localparam logic [16:0] CAS_DN_BASE = 17'h10000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        PLAY  = 2'd2,
        DONE  = 2'd3
    } cas_state_e;

endpackage

// File: rtl/cas_cell_gen.sv
// Bit-cell counter and pulse shaper: a clock pulse at the start of every cell and
// a second pulse at mid-cell when the data bit is 1.
module cas_cell_gen #(
    parameter int CELL_CYC  = 16,
    parameter int PULSE_CYC = 2
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic run_i,
    input  logic freeze_i,
    input  logic bit_i,
    output logic cell_start_o,
    output logic cell_end_o,
    output logic pulse_o
);

    localparam int CW = (CELL_CYC > 2) ? $clog2(CELL_CYC) : 1;
    localparam logic [CW-1:0] LAST     = CW'(CELL_CYC - 1);
    localparam logic [CW-1:0] HALF     = CW'(CELL_CYC / 2);
    localparam logic [CW-1:0] PW       = CW'(PULSE_CYC);
    localparam logic [CW-1:0] HALF_END = CW'(CELL_CYC / 2 + PULSE_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          step;

    assign step = run_i && !freeze_i;

    always_comb begin
        cnt_d = cnt_q;
        if (step) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cell_start_o = (cnt_q == '0);
    assign cell_end_o   = step && (cnt_q == LAST);
    assign pulse_o      = (cnt_q < PW) || (bit_i && (cnt_q >= HALF) && (cnt_q < HALF_END));

endmodule

// File: rtl/cas_player.sv
// Cassette image player: fetches bytes from the cassette RAM region and plays them
// MSB first as clock/data pulse cells on cas_bit, with one-byte prefetch.
module cas_player
    import trs80_cas_pkg::*;
#(
    parameter int CELL_CYC  = CELL_CYC_DEF,
    parameter int PULSE_CYC = PULSE_CYC_DEF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        start,
    input  logic        motor,
    input  logic [15:0] length,
    output logic        rd_req,
    output logic [15:0] rd_addr,
    input  logic        rd_ack,
    input  logic [7:0]  rd_data,
    output logic        cas_bit,
    output logic        busy,
    output logic        done,
    output logic        underrun,
    output cas_state_e  dbg_state
);

    cas_state_e  state_q;
    logic [15:0] len_q;
    logic [15:0] play_idx_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic [7:0]  hold_q;
    logic        hold_vld_q;
    logic        stall_q;
    logic        rd_req_q;
    logic [15:0] rd_addr_q;
    logic        cas_bit_q;
    logic        busy_q;
    logic        done_q;
    logic        underrun_q;

    logic        run, ack, prefetch, last_byte;
    logic        cell_start, cell_end, pulse;
    logic [16:0] next_idx;

    // Acks without an outstanding request (including after a reset) are dropped.
    assign ack       = rd_ack && rd_req_q;
    assign run       = (state_q == PLAY) && motor;
    assign next_idx  = {1'b0, play_idx_q} + 17'd1;
    assign last_byte = (next_idx == {1'b0, len_q});
    assign prefetch  = run && !stall_q && (bit_idx_q == 3'd0) && cell_start &&
                       (next_idx < {1'b0, len_q}) && !hold_vld_q && !rd_req_q;

    cas_cell_gen #(
        .CELL_CYC (CELL_CYC),
        .PULSE_CYC(PULSE_CYC)
    ) u_cell (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .run_i       (run),
        .freeze_i    (stall_q),
        .bit_i       (shift_q[7]),
        .cell_start_o(cell_start),
        .cell_end_o  (cell_end),
        .pulse_o     (pulse)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            play_idx_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            stall_q    <= 1'b0;
            rd_req_q   <= 1'b0;
            rd_addr_q  <= '0;
            cas_bit_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cas_bit_q <= run && !stall_q && pulse;
            if (ack) begin
                rd_req_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        len_q      <= length;
                        rd_addr_q  <= '0;
                        play_idx_q <= '0;
                        bit_idx_q  <= '0;
                        hold_vld_q <= 1'b0;
                        stall_q    <= 1'b0;
                        underrun_q <= 1'b0;
                        if (length != 16'd0) begin
                            state_q  <= PRIME;
                            busy_q   <= 1'b1;
                            rd_req_q <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                PRIME: begin
                    if (ack) begin
                        shift_q <= rd_data;
                        state_q <= PLAY;
                    end
                end
                PLAY: begin
                    if (prefetch) begin
                        rd_req_q  <= 1'b1;
                        rd_addr_q <= next_idx[15:0];
                    end
                    if (stall_q) begin
                        // Counter sits at 0 while stalled, so the late byte starts a fresh cell.
                        if (ack) begin
                            shift_q <= rd_data;
                            stall_q <= 1'b0;
                        end
                    end else begin
                        if (ack) begin
                            hold_q     <= rd_data;
                            hold_vld_q <= 1'b1;
                        end
                        if (cell_end) begin
                            if (bit_idx_q != 3'd7) begin
                                bit_idx_q <= bit_idx_q + 3'd1;
                                shift_q   <= {shift_q[6:0], 1'b0};
                            end else if (last_byte) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                bit_idx_q  <= '0;
                                play_idx_q <= next_idx[15:0];
                                hold_vld_q <= 1'b0;
                                if (hold_vld_q) begin
                                    shift_q <= hold_q;
                                end else if (ack) begin
                                    shift_q <= rd_data;
                                end else begin
                                    stall_q    <= 1'b1;
                                    underrun_q <= 1'b1;
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rd_req    = rd_req_q;
    assign rd_addr   = rd_addr_q;
    assign cas_bit   = cas_bit_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign underrun  = underrun_q;
    assign dbg_state = state_q;

endmodule
